// File: rtl/oam_dma_controller_pkg.sv
// Shared constants and state encoding for the OAM sprite DMA sequencer.
package oam_dma_controller_pkg;

    localparam logic [15:0] DEFAULT_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] DEFAULT_TARGET_ADDR  = 16'h2004;
    localparam int unsigned PAGE_W  = 8;
    localparam int unsigned COUNT_W = 8;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/oam_dma_controller.sv
// OAM sprite DMA: halts the 6502 via RDY and copies one page to OAMDATA
// as alternating get/put cycles. Every output comes straight from a flop.
module oam_dma_controller
    import oam_dma_controller_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = DEFAULT_TRIGGER_ADDR,
    parameter logic [15:0] TARGET_ADDR  = DEFAULT_TARGET_ADDR,
    parameter int unsigned XFER_COUNT   = 256
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_ce,
    input  logic [ADDR_W-1:0]   i_cpu_address,
    input  logic                i_cpu_rw,
    input  logic [DATA_W-1:0]   i_cpu_data,
    input  logic [DATA_W-1:0]   i_bus_data,
    output logic                o_rdy,
    output logic                o_dma_active,
    output logic [ADDR_W-1:0]   o_address,
    output logic                o_address_load_low,
    output logic                o_address_load_high,
    output logic                o_rw,
    output logic [DATA_W-1:0]   o_data
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(XFER_COUNT - 1);

    dma_state_e          state_q,   state_d;
    logic                parity_q,  parity_d;
    logic [PAGE_W-1:0]   page_q,    page_d;
    logic [COUNT_W-1:0]  count_q,   count_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                rdy_q,     rdy_d;
    logic                active_q,  active_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                strobe_q,  strobe_d;
    logic                rw_q,      rw_d;

    // Next state and the outputs that go with it, registered below.
    always_comb begin
        state_d   = state_q;
        parity_d  = ~parity_q;
        page_d    = page_q;
        count_d   = count_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        active_d  = active_q;
        address_d = address_q;
        strobe_d  = 1'b0;
        rw_d      = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (!i_cpu_rw && i_cpu_address == TRIGGER_ADDR) begin
                    page_d  = i_cpu_data;
                    state_d = ST_HALT;
                    rdy_d   = 1'b0;
                end
            end
            ST_HALT: begin
                // The 6502 only honours RDY on read cycles.
                if (i_cpu_rw) begin
                    active_d = 1'b1;
                    if (!parity_d) begin
                        state_d   = ST_READ;
                        address_d = {page_q, count_q};
                        strobe_d  = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                state_d   = ST_READ;
                address_d = {page_q, count_q};
                strobe_d  = 1'b1;
            end
            ST_READ: begin
                data_d    = i_bus_data;
                state_d   = ST_WRITE;
                address_d = TARGET_ADDR;
                rw_d      = 1'b0;
                strobe_d  = 1'b1;
            end
            ST_WRITE: begin
                if (count_q == LAST_COUNT) begin
                    count_d  = '0;
                    state_d  = ST_IDLE;
                    rdy_d    = 1'b1;
                    active_d = 1'b0;
                end else begin
                    count_d   = count_q + 1'b1;
                    state_d   = ST_READ;
                    address_d = {page_q, count_q + 1'b1};
                    strobe_d  = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                rdy_d    = 1'b1;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            parity_q  <= 1'b0;
            page_q    <= '0;
            count_q   <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b1;
            active_q  <= 1'b0;
            address_q <= '0;
            strobe_q  <= 1'b0;
            rw_q      <= 1'b1;
        end else if (i_ce) begin
            state_q   <= state_d;
            parity_q  <= parity_d;
            page_q    <= page_d;
            count_q   <= count_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            active_q  <= active_d;
            address_q <= address_d;
            strobe_q  <= strobe_d;
            rw_q      <= rw_d;
        end
    end

    assign o_rdy               = rdy_q;
    assign o_dma_active        = active_q;
    assign o_address           = address_q;
    assign o_address_load_low  = strobe_q;
    assign o_address_load_high = strobe_q;
    assign o_rw                = rw_q;
    assign o_data              = data_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: timeline model of the transfer checked every
// cycle, plus literal halted-cycle counts and first-cycle pins per scenario.
module tb_oam_dma_controller;
    import oam_dma_controller_pkg::*;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] TGT  = 16'h2004;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        cpu_rw = 1'b1;
    logic [15:0] cpu_addr = 16'h8000;
    logic [7:0]  cpu_data = 8'h00;
    logic [7:0]  bus_data;
    logic        rdy, act, ld_lo, ld_hi, rw;
    logic [15:0] addr;
    logic [7:0]  data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns the low address byte.
    assign bus_data = addr[7:0];

    oam_dma_controller dut (
        .i_clk               (clk),
        .i_reset_n           (rst_n),
        .i_ce                (ce),
        .i_cpu_address       (cpu_addr),
        .i_cpu_rw            (cpu_rw),
        .i_cpu_data          (cpu_data),
        .i_bus_data          (bus_data),
        .o_rdy               (rdy),
        .o_dma_active        (act),
        .o_address           (addr),
        .o_address_load_low  (ld_lo),
        .o_address_load_high (ld_hi),
        .o_rw                (rw),
        .o_data              (data)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Timeline model: cycle index since reset, trigger cycle, HALT release
    // cycle and first READ cycle (the next even cycle after release).
    int          cyc, m_t, m_h, m_r;
    logic [7:0]  m_page;

    function automatic bit model_done();
        return (m_r >= 0) && (cyc >= m_r + 512);
    endfunction

    function automatic bit model_busy();
        return (m_t >= 0) && !model_done();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_t <= -1; m_h <= -1; m_r <= -1; m_page <= 8'h00;
        end else if (ce) begin
            cyc <= cyc + 1;
            if (!model_busy() && !cpu_rw && cpu_addr == TRIG) begin
                m_t <= cyc; m_page <= cpu_data; m_h <= -1; m_r <= -1;
            end else if (m_t >= 0 && m_h < 0 && cpu_rw) begin
                m_h <= cyc;
                m_r <= (cyc % 2 == 1) ? cyc + 1 : cyc + 2;
            end
        end
    end

    // Per-test observations, cleared whenever the stimulus advances test_id.
    int          test_id = 0;
    int          last_id = -1;
    int          halted;
    bit          seen_act, seen_rd;
    logic        first_act_stb;
    logic [15:0] first_rd_addr;
    int          bad_reads;
    logic [7:0]  want_page = 8'h02;

    always @(negedge clk) begin : cmp
        logic [28:0] got, exp, mask;
        int k;
        if (test_id != last_id) begin
            last_id = test_id; halted = 0; seen_act = 0; seen_rd = 0;
            first_act_stb = 1'b0; first_rd_addr = 16'h0; bad_reads = 0;
        end
        if (rst_n) begin
            got  = {rdy, act, ld_lo, ld_hi, rw, addr, data};
            mask = '1;
            if (m_t < 0) begin
                exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
            end else if (model_done()) begin
                exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, TGT, 8'hFF};
            end else if (m_h < 0 || cyc <= m_h) begin
                exp  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
                mask = {5'h1F, 24'h0};
            end else if (cyc < m_r) begin
                exp  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00};
                mask = {5'h1F, 24'h0};
            end else begin
                k = cyc - m_r;
                if (k % 2 == 0) begin
                    exp  = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, m_page, 8'(k / 2), 8'h00};
                    mask = {5'h1F, 16'hFFFF, 8'h00};
                end else begin
                    exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, TGT, 8'((k - 1) / 2)};
                end
            end
            check($sformatf("cycle%0d", cyc), 64'(got & mask), 64'(exp & mask));
            if (ce && !rdy) halted++;
            if (act && !seen_act) begin seen_act = 1; first_act_stb = ld_lo; end
            if (ld_lo && rw && !seen_rd) begin seen_rd = 1; first_rd_addr = addr; end
            if (ld_lo && rw && addr[15:8] != want_page) bad_reads++;
        end
    end

    int ce_div = 1;
    int phase = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        phase++;
        ce = (ce_div == 1) || (phase % ce_div == 0);
    endtask

    task automatic align_parity(input int p);
        ce_div = 1; ce = 1'b1;
        for (int i = 0; i < 4 && (cyc % 2) != p; i++) tick();
    endtask

    task automatic trigger(input logic [7:0] page, input int extra);
        ce = 1'b1; cpu_rw = 1'b0; cpu_addr = TRIG; cpu_data = page;
        tick();
        for (int i = 0; i < extra; i++) begin
            cpu_rw = 1'b0; cpu_addr = 16'h0100; cpu_data = 8'hAA;
            tick();
        end
        cpu_rw = 1'b1; cpu_addr = 16'h8000;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 3000 && !model_done(); i++) tick();
        check({name, "_done"}, 64'(model_done()), 64'd1);
        ce_div = 1; ce = 1'b1;
        repeat (3) tick();
    endtask

    task automatic run_test(input string name, input int p, input logic [7:0] page,
                            input int extra, input int div, input int exp_halt);
        test_id++;
        want_page = page;
        align_parity(p);
        trigger(page, extra);
        ce_div = div;
        wait_done(name);
        check({name, "_halted"}, 64'(halted), 64'(exp_halt));
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({rdy, act, ld_lo, ld_hi, rw, addr, data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00}));
        @(negedge clk); #2; rst_n = 1'b1;
        repeat (2) tick();

        run_test("par0", 0, 8'h02, 0, 1, 513);
        check("par0_first_act_stb", 64'(first_act_stb), 64'd1);
        check("par0_first_read", 64'(first_rd_addr), 64'h0200);

        run_test("par1", 1, 8'h02, 0, 1, 514);
        check("par1_align_stb", 64'(first_act_stb), 64'd0);
        check("par1_first_read", 64'(first_rd_addr), 64'h0200);

        run_test("halt_ext", 0, 8'h02, 2, 1, 515);
        check("halt_ext_first_read", 64'(first_rd_addr), 64'h0200);

        run_test("ce_gated", 0, 8'h02, 0, 3, 513);
        check("ce_gated_page", 64'(bad_reads), 64'd0);

        // Retrigger with $05 during a page-$02 transfer must be ignored.
        test_id++;
        want_page = 8'h02;
        align_parity(0);
        trigger(8'h02, 0);
        repeat (100) tick();
        cpu_rw = 1'b0; cpu_addr = TRIG; cpu_data = 8'h05;
        tick();
        cpu_rw = 1'b1; cpu_addr = 16'h8000;
        wait_done("retrig");
        check("retrig_halted", 64'(halted), 64'd513);
        check("retrig_page", 64'(bad_reads), 64'd0);

        // Asynchronous reset at the $0280 read, then a clean restart at $0300.
        test_id++;
        align_parity(0);
        trigger(8'h02, 0);
        found = 0;
        for (int i = 0; i < 700 && !found; i++) begin
            if (ld_lo && rw && addr == 16'h0280) found = 1;
            else tick();
        end
        check("reach_0280", 64'(found), 64'd1);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check("midreset_outputs", 64'({rdy, act, ld_lo, ld_hi, rw, addr, data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00}));
        @(posedge clk); #1;
        check("midreset_hold", 64'({rdy, act, ld_lo, ld_hi, rw, addr, data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00}));
        @(negedge clk); #2; rst_n = 1'b1;
        tick();
        run_test("restart", 0, 8'h03, 0, 1, 513);
        check("restart_first_read", 64'(first_rd_addr), 64'h0300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
